booth_multiplier: RTL and testbench
===================================

BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand/result width; legal values are even and >= 4.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  request valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept a request.
REQ-006 SHALL have port: mul_src1  input  WIDTH  multiplicand.
REQ-007 SHALL have port: mul_src2  input  WIDTH  multiplier.
REQ-008 SHALL have port: mul_op  input  3  one-hot op: 001 mul.w (low half, signed), 010 mulh.w (high half, signed), 100 mulh.wu (high half, unsigned).
REQ-009 SHALL have port: flush  input  1  cancel any in-flight operation (exception/branch flush).
REQ-010 SHALL have port: out_valid  output  1  result valid.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port: mul_res  output  WIDTH  selected result half.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 SHALL accept a request on an edge where in_valid && in_ready && !flush, latching operands and mul_op, and entering CALC.
REQ-015 SHALL extend operands to WIDTH+2 bits at accept: sign-extend for 001/010, zero-extend for 100.
REQ-016 SHALL retire exactly one radix-4 Booth digit per CALC cycle: N = WIDTH/2+1 CALC edges; digit counter counts 0..N-1, then state goes to DONE.
REQ-017 SHALL make out_valid first visible exactly N edges after the accepting edge (17 for WIDTH=32).
REQ-018 SHALL form the exact product modulo 2^(2*WIDTH) of the extended operands.
REQ-019 SHALL drive mul_res as the OR of: {op[0]} & product[WIDTH-1:0], {op[1]} & signed product[2W-1:W], and {op[2]} & unsigned product[2W-1:W].
REQ-020 SHALL yield mul_res = 0 for mul_op = 000, and the OR of the selected halves for non-one-hot ops.
REQ-021 SHALL hold mul_res and out_valid stable in DONE until out_valid && out_ready, then return to IDLE on that edge.
REQ-022 SHALL keep in_ready low in CALC and DONE and ignore in_valid there: no overlap, no queuing.
REQ-023 SHALL, on flush high at any edge, force IDLE, drop the in-flight or completed result, and not accept on that edge; flush has priority over accept and retire.
REQ-024 SHALL drive mul_res = 0 whenever out_valid is low.

Reset
REQ-025 SHALL, on an edge with resetn low, set state IDLE, counter 0, and operand, accumulator and result registers 0, regardless of state (mid-CALC or DONE included).
REQ-026 SHALL give resetn priority over flush and all handshakes; after reset, in_ready=1, out_valid=0, mul_res=0.

Structure
REQ-027 SHALL place op encodings (MUL_W=3'b001, MULH_W=3'b010, MULH_WU=3'b100) and the FSM state type in shared package mul_pkg.
REQ-028 SHALL factor Booth digit decode and partial-product select (0, +-X, +-2X) into a combinational sub-module booth_pp_gen.
REQ-029 SHALL contain no vendor IP or inferred DSP multiplier.

Verification
REQ-030 SHALL cover: WIDTH=32, op 001, 0x00000003 * 0xFFFFFFFE -> mul_res 0xFFFFFFFA, out_valid exactly 17 cycles after accept.
REQ-031 SHALL cover: op 010, 0x80000000 * 0x80000000 -> 0x40000000; op 100, 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-032 SHALL cover: out_ready held low 5 cycles in DONE, with in_valid asserted -> mul_res/out_valid stable, in_ready 0, no new accept; pop on out_ready returns to IDLE.
REQ-033 SHALL cover: flush at the 8th CALC cycle -> IDLE next cycle, no out_valid; the following op 001 7*6 -> 0x0000002A.
REQ-034 SHALL cover: resetn low in the 10th CALC cycle -> IDLE, out_valid 0, mul_res 0; a new op then completes correctly.
REQ-035 SHALL cover: WIDTH=8, op 010, 0x80 * 0x7F -> 0xC0 with latency 5.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared op encodings, FSM state constants and radix-4 Booth digit decode
// for the iterative Booth multiplier.
package mul_pkg;

  localparam logic [2:0] MUL_W   = 3'b001;
  localparam logic [2:0] MULH_W  = 3'b010;
  localparam logic [2:0] MULH_WU = 3'b100;

  typedef logic [1:0] mul_state_t;
  localparam mul_state_t IDLE = 2'd0;
  localparam mul_state_t CALC = 2'd1;
  localparam mul_state_t DONE = 2'd2;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_sel_t;

  // Digit {y[2i+1], y[2i], y[2i-1]} -> partial-product weight in {0, +-1, +-2}
  function automatic booth_sel_t booth_decode(input logic [2:0] d);
    booth_sel_t s;
    s.neg = d[2] & ~(d[1] & d[0]);
    s.one = d[1] ^ d[0];
    s.two = (d == 3'b011) | (d == 3'b100);
    return s;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational radix-4 Booth partial product: selects 0, +-X or +-2X
// for one digit, at the full accumulator width.
module booth_pp_gen
  import mul_pkg::*;
#(
  parameter int PW = 64
) (
  input  logic [2:0]    digit,
  input  logic [PW-1:0] mcand,
  output logic [PW-1:0] pp
);

  booth_sel_t    sel;
  logic [PW-1:0] mag;

  always_comb begin
    sel = booth_decode(digit);
    mag = '0;
    if (sel.one)      mag = mcand;
    else if (sel.two) mag = {mcand[PW-2:0], 1'b0};
    pp = sel.neg ? (~mag + PW'(1)) : mag;
  end

endmodule

// File: rtl/booth_multiplier.sv
// Iterative radix-4 Booth multiplier: one digit per CALC cycle, result held
// in DONE until popped; flush cancels, synchronous active-low reset.
module booth_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] mul_src1,
  input  logic [WIDTH-1:0] mul_src2,
  input  logic [2:0]       mul_op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mul_res
);

  localparam int PW = 2 * WIDTH;
  localparam int EW = WIDTH + 2;
  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N);

  mul_state_t       state;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    mcand;
  logic [EW-1:0]    mplier;
  logic             prev;
  logic [PW-1:0]    acc;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             uns_q;

  logic             uns_in;
  logic [EW-1:0]    xext, yext;
  logic [PW-1:0]    pp;

  always_comb begin
    uns_in = (mul_op == MULH_WU);
    xext   = uns_in ? {2'b00, mul_src1} : {{2{mul_src1[WIDTH-1]}}, mul_src1};
    yext   = uns_in ? {2'b00, mul_src2} : {{2{mul_src2[WIDTH-1]}}, mul_src2};
  end

  booth_pp_gen #(.PW(PW)) u_pp (
    .digit (({mplier[1:0], prev})),
    .mcand (mcand),
    .pp    (pp)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prev   <= 1'b0;
      acc    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      uns_q  <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state  <= CALC;
          cnt    <= '0;
          mcand  <= {{(PW-EW){xext[EW-1]}}, xext};
          mplier <= yext;
          prev   <= 1'b0;
          acc    <= '0;
          op_q   <= mul_op;
          a_q    <= mul_src1;
          b_q    <= mul_src2;
          uns_q  <= uns_in;
        end
        CALC: begin
          acc    <= acc + pp;
          mcand  <= mcand << 2;
          mplier <= mplier >> 2;
          prev   <= mplier[1];
          if (cnt == CW'(N - 1)) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Only one product is formed; the other high half follows from the
  // identity U_hi = S_hi + (a<0 ? b : 0) + (b<0 ? a : 0) mod 2^WIDTH.
  logic [WIDTH-1:0] hi, corr, s_hi, u_hi;

  always_comb begin
    hi      = acc[PW-1:WIDTH];
    corr    = (a_q[WIDTH-1] ? b_q : '0) + (b_q[WIDTH-1] ? a_q : '0);
    s_hi    = uns_q ? hi - corr : hi;
    u_hi    = uns_q ? hi : hi + corr;
    mul_res = '0;
    if (out_valid)
      mul_res = ({WIDTH{op_q[0]}} & acc[WIDTH-1:0])
              | ({WIDTH{op_q[1]}} & s_hi)
              | ({WIDTH{op_q[2]}} & u_hi);
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Randomized and directed checks of booth_multiplier at WIDTH=32 and WIDTH=8
// against a plain-arithmetic product model.
module tb_booth_multiplier;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        iv32, ir32, ov32, ordy32, fl32;
  logic [31:0] s1_32, s2_32, res32;
  logic [2:0]  op32;

  logic        iv8, ir8, ov8, ordy8, fl8;
  logic [7:0]  s1_8, s2_8, res8;
  logic [2:0]  op8;

  int n_chk = 0;
  int n_err = 0;

  booth_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .resetn(resetn), .in_valid(iv32), .in_ready(ir32),
    .mul_src1(s1_32), .mul_src2(s2_32), .mul_op(op32), .flush(fl32),
    .out_valid(ov32), .out_ready(ordy32), .mul_res(res32)
  );

  booth_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .resetn(resetn), .in_valid(iv8), .in_ready(ir8),
    .mul_src1(s1_8), .mul_src2(s2_8), .mul_op(op8), .flush(fl8),
    .out_valid(ov8), .out_ready(ordy8), .mul_res(res8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full product in 64-bit arithmetic, then pick halves by op bits
  function automatic logic [63:0] model(input int w, input logic [63:0] a_in,
                                        input logic [63:0] b_in, input logic [2:0] op);
    logic [63:0] mask, a, b, sa, sb, ps, pu, r;
    mask = (64'd1 << w) - 64'd1;
    a  = a_in & mask;
    b  = b_in & mask;
    sa = a[w-1] ? (a | ~mask) : a;
    sb = b[w-1] ? (b | ~mask) : b;
    ps = sa * sb;
    pu = a * b;
    r  = '0;
    if (op[0]) r |= ps & mask;
    if (op[1]) r |= (ps >> w) & mask;
    if (op[2]) r |= (pu >> w) & mask;
    return r;
  endfunction

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input string tag, output logic [31:0] r);
    int lat;
    @(negedge clk);
    iv32 = 1'b1; s1_32 = a; s2_32 = b; op32 = op;
    @(posedge clk); #1;
    iv32 = 1'b0; lat = 0;
    while (!ov32 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, " lat"}, 64'(lat), 64'd17);
    chk({tag, " res"}, 64'(res32), model(32, 64'(a), 64'(b), op));
    r = res32;
    @(negedge clk); ordy32 = 1'b1;
    @(posedge clk); #1; ordy32 = 1'b0;
    chk({tag, " idle"}, 64'({ir32, ov32}), 64'b10);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input string tag, output logic [7:0] r);
    int lat;
    @(negedge clk);
    iv8 = 1'b1; s1_8 = a; s2_8 = b; op8 = op;
    @(posedge clk); #1;
    iv8 = 1'b0; lat = 0;
    while (!ov8 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, " lat"}, 64'(lat), 64'd5);
    chk({tag, " res"}, 64'(res8), model(8, 64'(a), 64'(b), op));
    r = res8;
    @(negedge clk); ordy8 = 1'b1;
    @(posedge clk); #1; ordy8 = 1'b0;
  endtask

  logic [31:0] r32, hold;
  logic [7:0]  r8;

  initial begin
    resetn = 1'b0;
    iv32 = 0; ordy32 = 0; fl32 = 0; s1_32 = 0; s2_32 = 0; op32 = 0;
    iv8 = 0; ordy8 = 0; fl8 = 0; s1_8 = 0; s2_8 = 0; op8 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset flags", 64'({ir32, ov32}), 64'b10);
    chk("reset res", 64'(res32), 64'd0);
    @(negedge clk); resetn = 1'b1;

    run32(32'h00000003, 32'hFFFFFFFE, 3'b001, "mulw 3x-2", r32);
    chk("mulw 3x-2 const", 64'(r32), 64'hFFFFFFFA);
    run32(32'h80000000, 32'h80000000, 3'b010, "mulh min", r32);
    chk("mulh min const", 64'(r32), 64'h40000000);
    run32(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b100, "mulhu max", r32);
    chk("mulhu max const", 64'(r32), 64'hFFFFFFFE);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      logic [2:0]  op;
      a = $urandom; b = $urandom;
      if (i % 6 == 0) a = 32'h7FFFFFFF;
      if (i % 6 == 1) b = 32'h80000000;
      op = (i < 12) ? (3'b001 << (i % 3)) : 3'($urandom_range(0, 7));
      run32(a, b, op, "rand32", r32);
    end

    // Stall in DONE with a competing request
    @(negedge clk);
    iv32 = 1'b1; s1_32 = 32'd12345; s2_32 = 32'hFFFF0001; op32 = 3'b010;
    @(posedge clk); #1;
    s1_32 = 32'd99; s2_32 = 32'd77; op32 = 3'b001;
    for (int k = 0; k < 100 && !ov32; k++) begin
      @(posedge clk); #1;
    end
    hold = res32;
    chk("stall first", 64'(hold), model(32, 64'd12345, 64'hFFFF0001, 3'b010));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("stall res", 64'(res32), 64'(hold));
      chk("stall flags", 64'({ir32, ov32}), 64'b01);
    end
    @(negedge clk); iv32 = 1'b0; ordy32 = 1'b1;
    @(posedge clk); #1; ordy32 = 1'b0;
    chk("stall pop", 64'({ir32, ov32}), 64'b10);
    repeat (3) @(posedge clk);
    #1;
    chk("no queued op", 64'({ir32, ov32}), 64'b10);

    // Flush in the 8th CALC cycle
    @(negedge clk);
    iv32 = 1'b1; s1_32 = 32'd1000; s2_32 = 32'd1000; op32 = 3'b001;
    @(posedge clk); #1; iv32 = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk); fl32 = 1'b1;
    @(posedge clk); #1; fl32 = 1'b0;
    chk("flush idle", 64'({ir32, ov32}), 64'b10);
    begin
      int seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        if (ov32) seen++;
      end
      chk("flush no valid", 64'(seen), 64'd0);
    end
    run32(32'd7, 32'd6, 3'b001, "after flush", r32);
    chk("after flush const", 64'(r32), 64'h2A);

    // Reset in the 10th CALC cycle
    @(negedge clk);
    iv32 = 1'b1; s1_32 = 32'hDEADBEEF; s2_32 = 32'h12345678; op32 = 3'b100;
    @(posedge clk); #1; iv32 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); resetn = 1'b0;
    @(posedge clk); #1;
    chk("midreset flags", 64'({ir32, ov32}), 64'b10);
    chk("midreset res", 64'(res32), 64'd0);
    @(negedge clk); resetn = 1'b1;
    run32(32'hCAFEF00D, 32'h0BADF00D, 3'b010, "after reset", r32);

    // WIDTH=8 instance
    run8(8'h80, 8'h7F, 3'b010, "w8 mulh", r8);
    chk("w8 mulh const", 64'(r8), 64'hC0);
    for (int i = 0; i < 16; i++)
      run8(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), "rand8", r8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
